tlb_cmd_unit: RTL

Executes the MIPS TLB-management instructions TLBP, TLBR, TLBWI and TLBWR.
- Sits between the CP0/exception stage and the TLB array.
- Drives the array's search, read and write ports.
- Returns a one-cycle result packet for CP0 to write back into Index, EntryHi, EntryLo0 and EntryLo1.
- Owns the Random register used by TLBWR.

---
 rtl/tlb_pkg.sv | 41 ++++
 rtl/tlb_random_ctr.sv | 27 ++
 rtl/tlb_cmd_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared encodings for the TLB command unit: op codes, EntryLo field layout,
// FSM state constants and the default array depth.
package tlb_pkg;

  localparam int unsigned TLBNUM_DEF = 16;

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_TLBWR = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // EntryLo layout {PFN, C, D, V, G}
  localparam int unsigned LO_G       = 0;
  localparam int unsigned LO_V       = 1;
  localparam int unsigned LO_D       = 2;
  localparam int unsigned LO_C_LSB   = 3;
  localparam int unsigned LO_C_MSB   = 5;
  localparam int unsigned LO_PFN_LSB = 6;
  localparam int unsigned LO_PFN_MSB = 25;

  function automatic logic is_write_op(input logic [1:0] op);
    return (op == OP_TLBWI) || (op == OP_TLBWR);
  endfunction

  function automatic logic [25:0] mk_lo(input logic [19:0] pfn, input logic [2:0] c,
                                        input logic d, input logic v, input logic g);
    logic [25:0] lo;
    lo = '0;
    lo[LO_PFN_MSB:LO_PFN_LSB] = pfn;
    lo[LO_C_MSB:LO_C_LSB]     = c;
    lo[LO_D]                  = d;
    lo[LO_V]                  = v;
    lo[LO_G]                  = g;
    return lo;
  endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: free-running down-counter that wraps to the top entry
// once it reaches the Wired boundary.
module tlb_random_ctr
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM = TLBNUM_DEF,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [IDXW-1:0] wired,
  output logic [IDXW-1:0] random
);

  localparam logic [IDXW-1:0] RND_MAX = IDXW'(TLBNUM - 1);

  // Wired >= TLBNUM-1 keeps the counter pinned at RND_MAX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      random <= RND_MAX;
    else if (random <= wired)
      random <= RND_MAX;
    else
      random <= random - IDXW'(1);
  end

endmodule

// File: rtl/tlb_cmd_unit.sv
// Executes TLBP/TLBR/TLBWI/TLBWR against the TLB array in a fixed
// accept -> execute -> respond sequence and returns a CP0 writeback packet.
module tlb_cmd_unit
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM = TLBNUM_DEF,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_code,
  input  logic [18:0]     cp0_vpn2,
  input  logic [7:0]      cp0_asid,
  input  logic [25:0]     cp0_lo0,
  input  logic [25:0]     cp0_lo1,
  input  logic [IDXW-1:0] cp0_index,
  input  logic [IDXW-1:0] cp0_wired,
  output logic [18:0]     tlb_s_vpn2,
  output logic [7:0]      tlb_s_asid,
  output logic            tlb_s_odd_page,
  input  logic            tlb_s_found,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [18:0]     tlb_r_vpn2,
  input  logic [7:0]      tlb_r_asid,
  input  logic            tlb_r_g,
  input  logic [24:0]     tlb_r_lo0,
  input  logic [24:0]     tlb_r_lo1,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [18:0]     tlb_w_vpn2,
  output logic [7:0]      tlb_w_asid,
  output logic            tlb_w_g,
  output logic [24:0]     tlb_w_lo0,
  output logic [24:0]     tlb_w_lo1,
  output logic            res_valid,
  output logic [1:0]      res_op,
  output logic            res_index_p,
  output logic [IDXW-1:0] res_index,
  output logic [18:0]     res_vpn2,
  output logic [7:0]      res_asid,
  output logic [25:0]     res_lo0,
  output logic [25:0]     res_lo1,
  output logic [IDXW-1:0] random
);

  logic [1:0]      state;
  logic [1:0]      sh_op;
  logic [18:0]     sh_vpn2;
  logic [7:0]      sh_asid;
  logic [25:0]     sh_lo0;
  logic [25:0]     sh_lo1;
  logic [IDXW-1:0] sh_index;
  logic [IDXW-1:0] sh_widx;
  logic            accept;

  tlb_random_ctr #(.TLBNUM(TLBNUM)) u_random (
    .clk    (clk),
    .resetn (resetn),
    .wired  (cp0_wired),
    .random (random)
  );

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= ST_EXEC;
        ST_EXEC: state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write index is frozen at accept so TLBWR ignores Random's later movement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_op    <= '0;
      sh_vpn2  <= '0;
      sh_asid  <= '0;
      sh_lo0   <= '0;
      sh_lo1   <= '0;
      sh_index <= '0;
      sh_widx  <= '0;
    end else if (accept) begin
      sh_op    <= op_code;
      sh_vpn2  <= cp0_vpn2;
      sh_asid  <= cp0_asid;
      sh_lo0   <= cp0_lo0;
      sh_lo1   <= cp0_lo1;
      sh_index <= cp0_index;
      sh_widx  <= (op_code == OP_TLBWR) ? random : cp0_index;
    end
  end

  assign tlb_s_vpn2     = sh_vpn2;
  assign tlb_s_asid     = sh_asid;
  assign tlb_s_odd_page = 1'b0;
  assign tlb_r_index    = sh_index;

  assign tlb_we      = (state == ST_EXEC) && is_write_op(sh_op);
  assign tlb_w_index = sh_widx;
  assign tlb_w_vpn2  = sh_vpn2;
  assign tlb_w_asid  = sh_asid;
  assign tlb_w_g     = sh_lo0[LO_G] & sh_lo1[LO_G];
  assign tlb_w_lo0   = sh_lo0[LO_PFN_MSB:LO_V];
  assign tlb_w_lo1   = sh_lo1[LO_PFN_MSB:LO_V];

  assign res_valid = (state == ST_RESP);

  // Search/read responses are captured straight into the result registers at
  // the end of EXEC, so they are stable throughout RESP and afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_op      <= '0;
      res_index_p <= 1'b0;
      res_index   <= '0;
      res_vpn2    <= '0;
      res_asid    <= '0;
      res_lo0     <= '0;
      res_lo1     <= '0;
    end else if (state == ST_EXEC) begin
      res_op      <= sh_op;
      res_index_p <= 1'b0;
      res_vpn2    <= '0;
      res_asid    <= '0;
      res_lo0     <= '0;
      res_lo1     <= '0;
      case (sh_op)
        OP_TLBP: begin
          res_index_p <= ~tlb_s_found;
          res_index   <= tlb_s_found ? tlb_s_index : '0;
        end
        OP_TLBR: begin
          res_index <= sh_index;
          res_vpn2  <= tlb_r_vpn2;
          res_asid  <= tlb_r_asid;
          res_lo0   <= {tlb_r_lo0, tlb_r_g};
          res_lo1   <= {tlb_r_lo1, tlb_r_g};
        end
        default: res_index <= sh_widx;
      endcase
    end
  end

endmodule
